// File: rtl/barrel_shift_pipe.sv
// Pipelined four-mode barrel shifter (LSL/LSR/ASR/ROR), one register per shift layer, valid/ready on both sides.
// Optional sticky output (OR of all discarded bits) is built when BARREL_SHIFT_PIPE_STICKY_EN is defined.
module barrel_shift_pipe #(
    parameter int N   = 8,
    parameter int SHW = 3
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [N-1:0]   IN_DATA,
    input  logic [SHW-1:0] IN_AMT,
    input  logic [1:0]     IN_MODE,
    input  logic           IN_VALID,
    output logic           IN_READY,
    output logic [N-1:0]   OUT_DATA,
    output logic           OUT_ZERO,
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
    output logic           OUT_STICKY,
`endif
    output logic           OUT_VALID,
    input  logic           OUT_READY
);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;

    // ASR fills from the current MSB; every layer preserves it, so it equals the operand MSB at accept.
    function automatic logic [N-1:0] layer_data(input logic [N-1:0] d, input logic [1:0] mode,
                                                input int sh);
        logic [N-1:0] ones;
        int           r;
        ones = '1;
        r    = sh % N;
        case (mode)
            MODE_LSL: layer_data = d << sh;
            MODE_LSR: layer_data = d >> sh;
            MODE_ASR: layer_data = (d >> sh) | (d[N-1] ? ~(ones >> sh) : '0);
            default:  layer_data = (d >> r) | (d << (N - r));
        endcase
    endfunction

`ifdef BARREL_SHIFT_PIPE_STICKY_EN
    function automatic logic layer_sticky(input logic [N-1:0] d, input logic [1:0] mode,
                                          input int sh);
        logic [N-1:0] ones;
        ones = '1;
        case (mode)
            MODE_LSL:           layer_sticky = |(d & ~(ones >> sh));
            MODE_LSR, MODE_ASR: layer_sticky = |(d & ~(ones << sh));
            default:            layer_sticky = 1'b0;
        endcase
    endfunction
`endif

    logic [N-1:0]   data_q   [SHW];
    logic [N-1:0]   data_d   [SHW];
    logic [N-1:0]   src_data [SHW];
    logic [SHW-1:0] amt_q    [SHW];
    logic [SHW-1:0] src_amt  [SHW];
    logic [1:0]     mode_q   [SHW];
    logic [1:0]     src_mode [SHW];
    logic [SHW-1:0] valid_q;
    logic [SHW-1:0] src_valid;
    logic           zero_q;
    logic           stall;
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
    logic [SHW-1:0] sticky_q;
    logic [SHW-1:0] sticky_d;
    logic [SHW-1:0] src_sticky;
`endif

    // Stage k consumes the previous stage's registers (stage 0 consumes the request) and applies 2**k.
    always_comb begin
        stall       = valid_q[SHW-1] && !OUT_READY;
        src_data    = '{default: '0};
        src_amt     = '{default: '0};
        src_mode    = '{default: '0};
        data_d      = '{default: '0};
        src_valid   = '0;
        src_data[0] = IN_DATA;
        src_amt[0]  = IN_AMT;
        src_mode[0] = IN_MODE;
        src_valid[0] = IN_VALID;
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
        src_sticky  = '0;
        sticky_d    = '0;
`endif
        for (int k = 1; k < SHW; k++) begin
            src_data[k]  = data_q[k-1];
            src_amt[k]   = amt_q[k-1];
            src_mode[k]  = mode_q[k-1];
            src_valid[k] = valid_q[k-1];
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
            src_sticky[k] = sticky_q[k-1];
`endif
        end
        for (int k = 0; k < SHW; k++) begin
            data_d[k] = src_amt[k][k] ? layer_data(src_data[k], src_mode[k], 1 << k) : src_data[k];
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
            sticky_d[k] = src_sticky[k] |
                          (src_amt[k][k] && layer_sticky(src_data[k], src_mode[k], 1 << k));
`endif
        end
    end

    // Global stall: all stages hold, bubbles included, so ordering is trivially preserved.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            zero_q  <= 1'b0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
            end
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
            sticky_q <= '0;
`endif
        end else if (!stall) begin
            valid_q <= src_valid;
            for (int k = 0; k < SHW; k++) begin
                if (src_valid[k]) begin
                    data_q[k] <= data_d[k];
                    amt_q[k]  <= src_amt[k];
                    mode_q[k] <= src_mode[k];
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
                    sticky_q[k] <= sticky_d[k];
`endif
                end
            end
            if (src_valid[SHW-1]) begin
                zero_q <= (data_d[SHW-1] == '0);
            end
        end
    end

    assign IN_READY  = !stall;
    assign OUT_DATA  = data_q[SHW-1];
    assign OUT_ZERO  = zero_q;
    assign OUT_VALID = valid_q[SHW-1];
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
    assign OUT_STICKY = sticky_q[SHW-1];
`endif

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Scoreboard bench for barrel_shift_pipe: an N=8/SHW=3 and an N=12/SHW=4 instance checked
// against a per-bit reference model; sticky is checked when BARREL_SHIFT_PIPE_STICKY_EN is defined.
module tb_barrel_shift_pipe;

    typedef struct {
        logic [15:0] data;
        logic        sticky;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  in_data8;
    logic [2:0]  in_amt8;
    logic [1:0]  in_mode8;
    logic        in_valid8, in_ready8, out_zero8, out_sticky8, out_valid8, out_ready8;
    logic [7:0]  out_data8;
    logic [11:0] in_data12;
    logic [3:0]  in_amt12;
    logic [1:0]  in_mode12;
    logic        in_valid12, in_ready12, out_zero12, out_sticky12, out_valid12, out_ready12;
    logic [11:0] out_data12;

    exp_t q8[$];
    exp_t q12[$];
    exp_t mon_e8, mon_e12;
    int   pop_cyc[$];
    int   n_pass = 0;
    int   n_checks = 0;
    int   cyc = 0;

    barrel_shift_pipe #(.N(8), .SHW(3)) u_dut8 (
        .CLK(clk), .RST(rst),
        .IN_DATA(in_data8), .IN_AMT(in_amt8), .IN_MODE(in_mode8),
        .IN_VALID(in_valid8), .IN_READY(in_ready8),
        .OUT_DATA(out_data8), .OUT_ZERO(out_zero8),
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
        .OUT_STICKY(out_sticky8),
`endif
        .OUT_VALID(out_valid8), .OUT_READY(out_ready8)
    );

    barrel_shift_pipe #(.N(12), .SHW(4)) u_dut12 (
        .CLK(clk), .RST(rst),
        .IN_DATA(in_data12), .IN_AMT(in_amt12), .IN_MODE(in_mode12),
        .IN_VALID(in_valid12), .IN_READY(in_ready12),
        .OUT_DATA(out_data12), .OUT_ZERO(out_zero12),
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
        .OUT_STICKY(out_sticky12),
`endif
        .OUT_VALID(out_valid12), .OUT_READY(out_ready12)
    );

`ifndef BARREL_SHIFT_PIPE_STICKY_EN
    assign out_sticky8  = 1'b0;
    assign out_sticky12 = 1'b0;
`endif

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: each result bit i is looked up directly from the operand for the total amount.
    function automatic void model(input logic [15:0] d, input int amt, input int mode, input int n,
                                  output logic [15:0] r, output logic st);
        int j;
        r  = '0;
        st = 1'b0;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: begin
                    j = i - amt;
                    r[i] = (j >= 0) ? d[j] : 1'b0;
                    if (i + amt >= n) st = st | d[i];
                end
                1: begin
                    j = i + amt;
                    r[i] = (j < n) ? d[j] : 1'b0;
                    if (i < amt) st = st | d[i];
                end
                2: begin
                    j = i + amt;
                    r[i] = (j < n) ? d[j] : d[n-1];
                    if (i < amt) st = st | d[i];
                end
                default: r[i] = d[(i + amt) % n];
            endcase
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready8_rule", in_ready8, !(out_valid8 && !out_ready8));
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out8: got %0h expected no output", out_data8);
                end else begin
                    mon_e8 = q8.pop_front();
                    check("data8", out_data8, mon_e8.data);
                    check("zero8", out_zero8, mon_e8.data == 16'h0);
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
                    check("sticky8", out_sticky8, mon_e8.sticky);
`endif
                    pop_cyc.push_back(cyc);
                end
            end
            if (out_valid12 && out_ready12) begin
                if (q12.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out12: got %0h expected no output", out_data12);
                end else begin
                    mon_e12 = q12.pop_front();
                    check("data12", out_data12, mon_e12.data);
                    check("zero12", out_zero12, mon_e12.data == 16'h0);
`ifdef BARREL_SHIFT_PIPE_STICKY_EN
                    check("sticky12", out_sticky12, mon_e12.sticky);
`endif
                end
            end
        end
    end

    task automatic push8(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m);
        exp_t e;
        logic hs;
        int   t;
        model({8'h0, d}, int'(a), int'(m), 8, e.data, e.sticky);
        in_data8 = d; in_amt8 = a; in_mode8 = m; in_valid8 = 1'b1;
        hs = 1'b0; t = 0;
        while (!hs && t < 200) begin
            @(negedge clk); hs = in_ready8;
            @(posedge clk); t++;
        end
        if (hs) q8.push_back(e);
        else begin n_checks++; $display("FAIL accept8_timeout: got no accept expected accept"); end
        #1 in_valid8 = 1'b0;
    endtask

    task automatic push12(input logic [11:0] d, input logic [3:0] a, input logic [1:0] m);
        exp_t e;
        logic hs;
        int   t;
        model({4'h0, d}, int'(a), int'(m), 12, e.data, e.sticky);
        in_data12 = d; in_amt12 = a; in_mode12 = m; in_valid12 = 1'b1;
        hs = 1'b0; t = 0;
        while (!hs && t < 200) begin
            @(negedge clk); hs = in_ready12;
            @(posedge clk); t++;
        end
        if (hs) q12.push_back(e);
        else begin n_checks++; $display("FAIL accept12_timeout: got no accept expected accept"); end
        #1 in_valid12 = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((q8.size() != 0 || q12.size() != 0) && t < 200) begin
            @(posedge clk); t++;
        end
        #1;
        check(name, q8.size() + q12.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic done;
        in_data8 = '0; in_amt8 = '0; in_mode8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b1;
        in_data12 = '0; in_amt12 = '0; in_mode12 = '0; in_valid12 = 1'b0; out_ready12 = 1'b1;

        #2;
        check("rst_out_valid", out_valid8, 1'b0);
        check("rst_out_data", out_data8, 8'h00);
        check("rst_out_zero", out_zero8, 1'b0);
        check("rst_out_sticky", out_sticky8, 1'b0);
        check("rst_in_ready", in_ready8, 1'b1);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases with latency check on the first
        push8(8'hB5, 3'd3, 2'b00);
        @(posedge clk); #1 check("lat_edge1_valid", out_valid8, 1'b0);
        @(posedge clk); #1 check("lat_edge2_valid", out_valid8, 1'b1);
        push8(8'h96, 3'd2, 2'b10);
        push8(8'h0F, 3'd4, 2'b01);
        push8(8'h81, 3'd1, 2'b11);
        push8(8'h80, 3'd7, 2'b10);
        push8(8'h01, 3'd0, 2'b00);
        drain("drain_directed");

        // Backpressure: four back-to-back with OUT_READY low for 5 edges
        pop_cyc.delete();
        out_ready8 = 1'b0;
        fork
            begin
                push8(8'h11, 3'd1, 2'b00);
                push8(8'h22, 3'd2, 2'b01);
                push8(8'h93, 3'd3, 2'b10);
                push8(8'h44, 3'd5, 2'b11);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", in_ready8, 1'b0);
                check("stall_out_valid", out_valid8, 1'b1);
                @(posedge clk); #1 out_ready8 = 1'b1;
            end
        join
        drain("drain_stall");
        check("stall_pop_count", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) check("stall_pop_span", pop_cyc[3] - pop_cyc[0], 3);

        // Reset with three requests in flight
        push8(8'hAA, 3'd1, 2'b00);
        push8(8'hBB, 3'd2, 2'b01);
        push8(8'hCC, 3'd3, 2'b10);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid8, 1'b0);
        check("midrst_in_ready", in_ready8, 1'b1);
        q8.delete();
        q12.delete();
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        push8(8'h5A, 3'd2, 2'b11);
        drain("drain_post_reset");

        // Randomized traffic with random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    push8(8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1 out_ready8 = ($urandom_range(0, 3) != 0);
                end
                out_ready8 = 1'b1;
            end
        join
        drain("drain_random8");

        // Non-power-of-two width, amounts up to and beyond N
        push12(12'h801, 4'd13, 2'b11);
        push12(12'h801, 4'd12, 2'b00);
        push12(12'h800, 4'd15, 2'b10);
        push12(12'hFFF, 4'd12, 2'b01);
        for (int i = 0; i < 30; i++) begin
            push12(12'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end
        drain("drain_random12");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
